// File: rtl/exec_operand_stage.sv
// Decode->execute and execute->memory pipeline registers with stall bubbling,
// operand bypass resolution and a saturating stall-cycle counter.
module exec_operand_stage #(
   parameter int DATA_W      = 32,
   parameter int CTRL_W      = 8,
   parameter int IMM_SEL_BIT = 0,
   parameter int CNT_W       = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic              i_d_valid,
   input  logic [DATA_W-1:0] i_d_rs_data,
   input  logic [DATA_W-1:0] i_d_rt_data,
   input  logic [DATA_W-1:0] i_d_imm,
   input  logic [CTRL_W-1:0] i_d_ctrl,
   input  logic [4:0]        i_d_dest,
   input  logic              i_me_rs_bypass,
   input  logic              i_me_rt_bypass,
   input  logic              i_we_rs_bypass,
   input  logic              i_we_rt_bypass,
   input  logic              i_wm_rt_bypass,
   input  logic [DATA_W-1:0] i_m_alu_result,
   input  logic [DATA_W-1:0] i_wb_data,
   output logic              o_e_valid,
   output logic [CTRL_W-1:0] o_e_ctrl,
   output logic [4:0]        o_e_dest,
   output logic [DATA_W-1:0] o_e_op_a,
   output logic [DATA_W-1:0] o_e_op_b,
   output logic              o_m_valid,
   output logic [CTRL_W-1:0] o_m_ctrl,
   output logic [4:0]        o_m_dest,
   output logic [DATA_W-1:0] o_m_store_data,
   output logic [CNT_W-1:0]  o_stall_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              e_valid_r;
   logic [CTRL_W-1:0] e_ctrl_r;
   logic [4:0]        e_dest_r;
   logic [DATA_W-1:0] e_rs_r;
   logic [DATA_W-1:0] e_rt_r;
   logic [DATA_W-1:0] e_imm_r;
   logic              m_valid_r;
   logic [CTRL_W-1:0] m_ctrl_r;
   logic [4:0]        m_dest_r;
   logic [DATA_W-1:0] m_store_r;
   logic [CNT_W-1:0]  stall_cnt_r;

   logic [DATA_W-1:0] rs_res_s;
   logic [DATA_W-1:0] rt_res_s;
   logic [DATA_W-1:0] op_b_s;
   logic [DATA_W-1:0] store_s;

   // E register: flush or stall inserts a bubble, operands hold while stalled
   always_ff @(posedge clock) begin
      if (!reset) begin
         e_valid_r <= 1'b0;
         e_ctrl_r  <= {CTRL_W{1'b0}};
         e_dest_r  <= 5'd0;
         e_rs_r    <= {DATA_W{1'b0}};
         e_rt_r    <= {DATA_W{1'b0}};
         e_imm_r   <= {DATA_W{1'b0}};
      end else if (i_flush || i_stall) begin
         e_valid_r <= 1'b0;
         e_ctrl_r  <= {CTRL_W{1'b0}};
      end else begin
         e_valid_r <= i_d_valid;
         e_ctrl_r  <= i_d_valid ? i_d_ctrl : {CTRL_W{1'b0}};
         e_dest_r  <= i_d_dest;
         e_rs_r    <= i_d_rs_data;
         e_rt_r    <= i_d_rt_data;
         e_imm_r   <= i_d_imm;
      end
   end

   // Operand resolution: the mem-stage result is newer than writeback, so it wins
   always_comb begin
      rs_res_s = e_rs_r;
      rt_res_s = e_rt_r;
      if (e_valid_r && i_me_rs_bypass) begin
         rs_res_s = i_m_alu_result;
      end else if (e_valid_r && i_we_rs_bypass) begin
         rs_res_s = i_wb_data;
      end else begin
         rs_res_s = e_rs_r;
      end
      if (e_valid_r && i_me_rt_bypass) begin
         rt_res_s = i_m_alu_result;
      end else if (e_valid_r && i_we_rt_bypass) begin
         rt_res_s = i_wb_data;
      end else begin
         rt_res_s = e_rt_r;
      end
   end

   // Operand B picks the immediate; store data always comes from resolved rt
   always_comb begin
      op_b_s  = rt_res_s;
      store_s = m_store_r;
      if (e_ctrl_r[IMM_SEL_BIT]) begin
         op_b_s = e_imm_r;
      end else begin
         op_b_s = rt_res_s;
      end
      if (m_valid_r && i_wm_rt_bypass) begin
         store_s = i_wb_data;
      end else begin
         store_s = m_store_r;
      end
   end

   // M register: unconditional capture so E bubbles flow downstream
   always_ff @(posedge clock) begin
      if (!reset) begin
         m_valid_r <= 1'b0;
         m_ctrl_r  <= {CTRL_W{1'b0}};
         m_dest_r  <= 5'd0;
         m_store_r <= {DATA_W{1'b0}};
      end else begin
         m_valid_r <= e_valid_r;
         m_ctrl_r  <= e_ctrl_r;
         m_dest_r  <= e_dest_r;
         m_store_r <= rt_res_s;
      end
   end

   // Stall-cycle counter, saturating at all-ones
   always_ff @(posedge clock) begin
      if (!reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (i_stall && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign o_e_valid      = e_valid_r;
   assign o_e_ctrl       = e_ctrl_r;
   assign o_e_dest       = e_dest_r;
   assign o_e_op_a       = rs_res_s;
   assign o_e_op_b       = op_b_s;
   assign o_m_valid      = m_valid_r;
   assign o_m_ctrl       = m_ctrl_r;
   assign o_m_dest       = m_dest_r;
   assign o_m_store_data = store_s;
   assign o_stall_count  = stall_cnt_r;

endmodule

// File: tb/tb_exec_operand_stage.sv
// Self-checking bench for exec_operand_stage: directed scenarios plus random
// traffic against a transaction-level pipeline model.
module tb_exec_operand_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        stall, flush, d_valid;
   logic [31:0] d_rs, d_rt, d_imm, m_alu, wb_data;
   logic [7:0]  d_ctrl;
   logic [4:0]  d_dest;
   logic        me_rs, me_rt, we_rs, we_rt, wm_rt;

   logic        e_valid, m_valid, s_e_valid, s_m_valid;
   logic [7:0]  e_ctrl, m_ctrl, s_e_ctrl, s_m_ctrl;
   logic [4:0]  e_dest, m_dest, s_e_dest, s_m_dest;
   logic [31:0] op_a, op_b, store, stall_count;
   logic [31:0] s_op_a, s_op_b, s_store;
   logic [2:0]  s_stall_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   exec_operand_stage dut (
      .clock(clock), .reset(reset), .i_stall(stall), .i_flush(flush),
      .i_d_valid(d_valid), .i_d_rs_data(d_rs), .i_d_rt_data(d_rt), .i_d_imm(d_imm),
      .i_d_ctrl(d_ctrl), .i_d_dest(d_dest),
      .i_me_rs_bypass(me_rs), .i_me_rt_bypass(me_rt), .i_we_rs_bypass(we_rs),
      .i_we_rt_bypass(we_rt), .i_wm_rt_bypass(wm_rt),
      .i_m_alu_result(m_alu), .i_wb_data(wb_data),
      .o_e_valid(e_valid), .o_e_ctrl(e_ctrl), .o_e_dest(e_dest),
      .o_e_op_a(op_a), .o_e_op_b(op_b),
      .o_m_valid(m_valid), .o_m_ctrl(m_ctrl), .o_m_dest(m_dest),
      .o_m_store_data(store), .o_stall_count(stall_count)
   );

   exec_operand_stage #(.CNT_W(3)) dut_sat (
      .clock(clock), .reset(reset), .i_stall(stall), .i_flush(flush),
      .i_d_valid(d_valid), .i_d_rs_data(d_rs), .i_d_rt_data(d_rt), .i_d_imm(d_imm),
      .i_d_ctrl(d_ctrl), .i_d_dest(d_dest),
      .i_me_rs_bypass(me_rs), .i_me_rt_bypass(me_rt), .i_we_rs_bypass(we_rs),
      .i_we_rt_bypass(we_rt), .i_wm_rt_bypass(wm_rt),
      .i_m_alu_result(m_alu), .i_wb_data(wb_data),
      .o_e_valid(s_e_valid), .o_e_ctrl(s_e_ctrl), .o_e_dest(s_e_dest),
      .o_e_op_a(s_op_a), .o_e_op_b(s_op_b),
      .o_m_valid(s_m_valid), .o_m_ctrl(s_m_ctrl), .o_m_dest(s_m_dest),
      .o_m_store_data(s_store), .o_stall_count(s_stall_count)
   );

   // Reference model: one instruction record per stage
   typedef struct {
      bit valid; bit [7:0] ctrl; bit [4:0] dest;
      bit [31:0] rs; bit [31:0] rt; bit [31:0] imm;
   } e_rec_t;
   typedef struct {
      bit valid; bit [7:0] ctrl; bit [4:0] dest; bit [31:0] store;
   } m_rec_t;

   e_rec_t ex;
   m_rec_t mm;
   longint cnt32, cnt3;

   // Newest producer wins; a bubble ignores every bypass
   function automatic bit [31:0] newest(bit from_mem, bit from_wb, bit [31:0] own);
      if (!ex.valid) return own;
      if (from_mem) return m_alu;
      if (from_wb) return wb_data;
      return own;
   endfunction

   function automatic bit [31:0] exp_a();
      return newest(me_rs, we_rs, ex.rs);
   endfunction

   function automatic bit [31:0] exp_rt();
      return newest(me_rt, we_rt, ex.rt);
   endfunction

   function automatic bit [31:0] exp_b();
      return ex.ctrl[0] ? ex.imm : exp_rt();
   endfunction

   function automatic bit [31:0] exp_store();
      return (mm.valid && wm_rt) ? wb_data : mm.store;
   endfunction

   task automatic model_clock();
      if (!reset) begin
         ex = '{default: 0};
         mm = '{default: 0};
         cnt32 = 0;
         cnt3 = 0;
      end else begin
         mm.valid = ex.valid; mm.ctrl = ex.ctrl; mm.dest = ex.dest; mm.store = exp_rt();
         if (flush || stall) begin
            ex.valid = 0; ex.ctrl = 0;
         end else begin
            ex.valid = d_valid; ex.ctrl = d_valid ? d_ctrl : 8'h00; ex.dest = d_dest;
            ex.rs = d_rs; ex.rt = d_rt; ex.imm = d_imm;
         end
         if (stall) begin
            cnt32 = (cnt32 >= 64'hFFFF_FFFF) ? cnt32 : cnt32 + 1;
            cnt3  = (cnt3 >= 7) ? cnt3 : cnt3 + 1;
         end
      end
   endtask

   task automatic tick();
      model_clock();
      @(posedge clock);
      #1;
   endtask

   task automatic quiet();
      stall = 0; flush = 0; me_rs = 0; me_rt = 0; we_rs = 0; we_rt = 0; wm_rt = 0;
   endtask

   task automatic load_d(bit v, bit [31:0] rs, bit [31:0] rt, bit [31:0] imm, bit [7:0] ctrl, bit [4:0] dest);
      d_valid = v; d_rs = rs; d_rt = rt; d_imm = imm; d_ctrl = ctrl; d_dest = dest;
   endtask

   task automatic test_reset();
      reset = 0;
      for (int i = 0; i < 2; i++) begin
         {stall, flush, d_valid, me_rs, me_rt, we_rs, we_rt, wm_rt} = 8'($urandom);
         d_rs = $urandom; d_rt = $urandom; d_imm = $urandom; m_alu = $urandom; wb_data = $urandom;
         d_ctrl = 8'($urandom); d_dest = 5'($urandom);
         tick();
      end
      #1;
      n_tests++;
      if ({e_valid, e_ctrl, e_dest, m_valid, m_ctrl, m_dest} !== 28'd0) begin
         n_fail++; $display("FAIL reset_ctrl got %h want 0", {e_valid, e_ctrl, e_dest, m_valid, m_ctrl, m_dest});
      end
      n_tests++;
      if ({op_a, op_b} !== 64'd0) begin
         n_fail++; $display("FAIL reset_ops got a=%h b=%h want 0", op_a, op_b);
      end
      n_tests++;
      if (store !== 32'd0 || stall_count !== 32'd0 || s_stall_count !== 3'd0) begin
         n_fail++; $display("FAIL reset_store_cnt got st=%h cnt=%0d sat=%0d want 0", store, stall_count, s_stall_count);
      end
      reset = 1; quiet();
      load_d(1, 32'd5, 32'd7, 32'h99, 8'h00, 5'd3);
      tick();
      load_d(0, 32'h0, 32'h0, 32'h0, 8'h00, 5'd0);
      #1;
      n_tests++;
      if (op_a !== 32'd5 || op_b !== 32'd7) begin
         n_fail++; $display("FAIL first_capture got a=%0d b=%0d want 5 7", op_a, op_b);
      end
   endtask

   task automatic test_bypass_priority();
      bit [2:0] sel [3] = '{3'b111, 3'b011, 3'b000};
      bit [31:0] want [3] = '{32'hAA, 32'hBB, 32'h1};
      quiet();
      load_d(1, 32'h1, 32'h2, 32'h0, 8'h00, 5'd4);
      tick();
      m_alu = 32'hAA; wb_data = 32'hBB;
      for (int i = 0; i < 3; i++) begin
         me_rs = sel[i][2]; we_rs = sel[i][1];
         #1;
         n_tests++;
         if (op_a !== want[i]) begin
            n_fail++; $display("FAIL bypass_prio[%0d] got %h want %h", i, op_a, want[i]);
         end
      end
      load_d(0, 32'h44, 32'h55, 32'h0, 8'hFF, 5'd1);
      me_rs = 0; we_rs = 0;
      tick();
      me_rs = 1; we_rs = 1; me_rt = 1;
      #1;
      n_tests++;
      if (op_a !== 32'h44 || op_b !== 32'h55 || e_ctrl !== 8'h00) begin
         n_fail++; $display("FAIL bypass_invalid got a=%h b=%h ctrl=%h want 44 55 00", op_a, op_b, e_ctrl);
      end
      quiet();
   endtask

   task automatic test_immediate();
      quiet();
      load_d(1, 32'h0, 32'h20, 32'h10, 8'h01, 5'd7);
      tick();
      me_rt = 1; m_alu = 32'h30;
      #1;
      n_tests++;
      if (op_b !== 32'h10) begin
         n_fail++; $display("FAIL imm_sel got %h want 10", op_b);
      end
      tick();
      quiet(); m_alu = 32'h0;
      #1;
      n_tests++;
      if (store !== 32'h30 || m_valid !== 1'b1 || m_dest !== 5'd7) begin
         n_fail++; $display("FAIL imm_store got st=%h v=%b d=%0d want 30 1 7", store, m_valid, m_dest);
      end
   endtask

   task automatic test_stall_bubble();
      longint c0;
      quiet();
      load_d(1, 32'h111, 32'h222, 32'h0, 8'h5A, 5'd9);
      tick();
      c0 = cnt32;
      load_d(1, 32'hABC, 32'hDEF, 32'h0, 8'hC4, 5'd12);
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_tests++;
         if (e_valid !== 1'b0 || e_ctrl !== 8'h00) begin
            n_fail++; $display("FAIL stall_bubble[%0d] got v=%b c=%h want 0 00", i, e_valid, e_ctrl);
         end
      end
      n_tests++;
      if (m_valid !== 1'b0 || stall_count !== 32'(c0 + 2)) begin
         n_fail++; $display("FAIL stall_m_cnt got mv=%b cnt=%0d want 0 %0d", m_valid, stall_count, c0 + 2);
      end
      stall = 0;
      tick();
      n_tests++;
      if (e_valid !== 1'b1 || e_ctrl !== 8'hC4 || op_a !== 32'hABC || m_valid !== 1'b0) begin
         n_fail++; $display("FAIL stall_release got v=%b c=%h a=%h mv=%b want 1 c4 abc 0", e_valid, e_ctrl, op_a, m_valid);
      end
   endtask

   task automatic test_flush_stall();
      longint c0;
      quiet();
      load_d(1, 32'h3, 32'h4, 32'h0, 8'h32, 5'd17);
      tick();
      c0 = cnt32;
      load_d(1, 32'h5, 32'h6, 32'h0, 8'h77, 5'd18);
      flush = 1; stall = 1;
      tick();
      quiet();
      #1;
      n_tests++;
      if (e_valid !== 1'b0 || e_ctrl !== 8'h00 || stall_count !== 32'(c0 + 1)) begin
         n_fail++; $display("FAIL flush_stall_e got v=%b c=%h cnt=%0d want 0 00 %0d", e_valid, e_ctrl, stall_count, c0 + 1);
      end
      n_tests++;
      if (m_valid !== 1'b1 || m_ctrl !== 8'h32 || m_dest !== 5'd17 || store !== 32'h4) begin
         n_fail++; $display("FAIL flush_stall_m got v=%b c=%h d=%0d st=%h want 1 32 17 4", m_valid, m_ctrl, m_dest, store);
      end
   endtask

   task automatic test_wm_bypass();
      quiet();
      load_d(1, 32'h0, 32'h11, 32'h0, 8'h00, 5'd2);
      tick();
      load_d(0, 32'h0, 32'h11, 32'h0, 8'h00, 5'd2);
      tick();
      wm_rt = 1; wb_data = 32'h22;
      #1;
      n_tests++;
      if (store !== 32'h22) begin
         n_fail++; $display("FAIL wm_bypass_valid got %h want 22", store);
      end
      wm_rt = 0;
      tick();
      tick();
      wm_rt = 1;
      #1;
      n_tests++;
      if (m_valid !== 1'b0 || store !== 32'h11) begin
         n_fail++; $display("FAIL wm_bypass_invalid got v=%b st=%h want 0 11", m_valid, store);
      end
      quiet();
   endtask

   task automatic test_saturation();
      quiet();
      stall = 1;
      for (int i = 0; i < 10; i++) tick();
      stall = 0;
      n_tests++;
      if (s_stall_count !== 3'd7 || stall_count !== 32'(cnt32)) begin
         n_fail++; $display("FAIL saturation got sat=%0d cnt=%0d want 7 %0d", s_stall_count, stall_count, cnt32);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 59) != 0);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 6) == 0);
         {d_valid, me_rs, me_rt, we_rs, we_rt, wm_rt} = 6'($urandom);
         d_rs = $urandom; d_rt = $urandom; d_imm = $urandom; m_alu = $urandom; wb_data = $urandom;
         d_ctrl = 8'($urandom); d_dest = 5'($urandom);
         #1;
         n_tests++;
         if ({e_valid, e_ctrl, e_dest, m_valid, m_ctrl, m_dest} !== {ex.valid, ex.ctrl, ex.dest, mm.valid, mm.ctrl, mm.dest}) begin
            n_fail++; $display("FAIL rand_ctrl[%0d] got %h want %h", i, {e_valid, e_ctrl, e_dest, m_valid, m_ctrl, m_dest},
                               {ex.valid, ex.ctrl, ex.dest, mm.valid, mm.ctrl, mm.dest});
         end
         n_tests++;
         if (op_a !== exp_a() || op_b !== exp_b() || store !== exp_store()) begin
            n_fail++; $display("FAIL rand_data[%0d] got a=%h b=%h st=%h want %h %h %h", i, op_a, op_b, store, exp_a(), exp_b(), exp_store());
         end
         n_tests++;
         if (stall_count !== 32'(cnt32) || s_stall_count !== 3'(cnt3)) begin
            n_fail++; $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i, stall_count, s_stall_count, cnt32, cnt3);
         end
         tick();
      end
      reset = 1;
   endtask

   initial begin
      quiet();
      load_d(0, 32'h0, 32'h0, 32'h0, 8'h00, 5'd0);
      m_alu = 32'h0; wb_data = 32'h0;
      ex = '{default: 0};
      mm = '{default: 0};
      cnt32 = 0; cnt3 = 0;
      #1;
      test_reset();
      test_bypass_priority();
      test_immediate();
      test_stall_bubble();
      test_flush_stall();
      test_wm_bypass();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_operand_stage.md
Name: exec_operand_stage

Overview:
- Consumer side of the hazard detection controller's stall/bypass interface.
- Holds the decode→execute and execute→memory pipeline registers and turns stall into bubble insertion.
- Applies the mem→exec, wb→exec and wb→mem bypass selects to produce final ALU operands and store data.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32, datapath width.
- CTRL_W, 8, width of the opaque control bundle carried down the pipe.
- IMM_SEL_BIT, 0, index in ctrl; 1 = operand B is the immediate.
- CNT_W, 32, stall counter width.

Ports:
clock  in  1  pipeline clock
reset  in  1  synchronous, active-low reset
i_stall  in  1  load-use stall from hazard controller
i_flush  in  1  kill instruction entering E (branch/jump redirect)
i_d_valid  in  1  decode-stage instruction valid
i_d_rs_data  in  DATA_W  regfile rs read
i_d_rt_data  in  DATA_W  regfile rt read
i_d_imm  in  DATA_W  extended immediate
i_d_ctrl  in  CTRL_W  decoded control bundle
i_d_dest  in  5  destination register address
i_me_rs_bypass  in  1  E rs takes mem-stage ALU result
i_me_rt_bypass  in  1  E rt takes mem-stage ALU result
i_we_rs_bypass  in  1  E rs takes writeback data
i_we_rt_bypass  in  1  E rt takes writeback data
i_wm_rt_bypass  in  1  M store data takes writeback data
i_m_alu_result  in  DATA_W  result currently in memory stage
i_wb_data  in  DATA_W  value currently being written back
o_e_valid  out  1  E-stage instruction valid
o_e_ctrl  out  CTRL_W  E-stage control
o_e_dest  out  5  E-stage destination
o_e_op_a  out  DATA_W  resolved ALU operand A
o_e_op_b  out  DATA_W  resolved ALU operand B
o_m_valid  out  1  M-stage valid
o_m_ctrl  out  CTRL_W  M-stage control
o_m_dest  out  5  M-stage destination
o_m_store_data  out  DATA_W  resolved store data
o_stall_count  out  CNT_W  cycles with i_stall high

Behaviour:
- Reset (reset=0 at posedge): all registers and outputs 0 on that edge; overrides everything, including mid-stall/mid-flush.
- E register, per posedge:
  - i_flush=1 → e_valid=0, e_ctrl=0 (bubble); flush wins over stall.
  - else i_stall=1 → e_valid=0, e_ctrl=0; e_rs/e_rt/e_imm/e_dest hold. Upstream holds D during stall.
  - else → capture i_d_* (e_valid=i_d_valid; if i_d_valid=0 then ctrl captured as 0).
- Resolved rs/rt are combinational from the current E register and current-cycle bypass inputs:
  - rs = me_rs ? i_m_alu_result : we_rs ? i_wb_data : e_rs.
  - rt is resolved the same way.
  - Mem has priority over wb when both are asserted (newest value).
- When e_valid=0, all E bypass selects are ignored and registered values are passed through.
- o_e_op_a = resolved rs.
- o_e_op_b = e_ctrl[IMM_SEL_BIT] ? e_imm : resolved rt.
- Store data forwarded to M is always resolved rt, never the immediate.
- M register, per posedge:
  - Captures o_e_valid, e_ctrl, e_dest and resolved rt unconditionally.
  - Stall and flush do not affect M; the bubble propagates.
- o_m_store_data = (m_valid & i_wm_rt_bypass) ? i_wb_data : m_store. Combinational; i_wm_rt_bypass is ignored when m_valid=0.
- Latency: D→E is 1 cycle, E→M is 1 cycle. Bypass muxes add 0 cycles.
- Stall counter:
  - +1 on each posedge with i_stall=1, including when i_flush=1 in the same cycle.
  - Saturates at all-ones with no wrap.
  - Cleared only by reset.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs → all outputs 0, o_stall_count=0. Release reset, then capture D {valid=1, rs=5, rt=7, ctrl=0} → next cycle o_e_op_a=5, o_e_op_b=7.
- Bypass priority: E holds rs=1; drive i_m_alu_result=0xAA, i_wb_data=0xBB.
  - me_rs=1, we_rs=1 → o_e_op_a=0xAA.
  - me_rs=0, we_rs=1 → 0xBB.
  - Both 0 → 1.
- Immediate select: ctrl[0]=1, imm=0x10, rt=0x20, me_rt=1 with m_alu=0x30 → o_e_op_b=0x10; one cycle later the captured o_m_store_data=0x30.
- Stall bubble: i_stall=1 for 2 cycles while D holds instr X → o_e_valid=0 and o_e_ctrl=0 for 2 cycles, M receives 2 bubbles, stall_count=2. Deassert → X appears in E on the next cycle.
- Flush+stall together: i_flush=1, i_stall=1 → E bubble, stall_count increments by 1, M still captures the prior E instruction.
- WB→M bypass and saturation:
  - m_valid=1, m_store=0x11, i_wm_rt_bypass=1, i_wb_data=0x22 → o_m_store_data=0x22.
  - Same with m_valid=0 → 0x11.
  - With CNT_W=3, stall for 10 cycles → o_stall_count=7.
